// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_stage : ID/EX register with ALU control decode and EX/MEM, MEM/WB |
// |                   operand forwarding.                                       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module alu_issue_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [1:0]  id_aluop_i,
    input  logic [5:0]  id_funct_i,
    input  logic        id_alusrc_i,
    input  logic        id_regdst_i,
    input  logic        id_regwrite_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [31:0] id_imm_i,
    input  logic        exmem_regwrite_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [31:0] exmem_result_i,
    input  logic        memwb_regwrite_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_result_i,
    output logic        ex_valid_o,
    output logic [3:0]  ctrl_o,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [31:0] ex_rt_data_o,
    output logic [4:0]  ex_wreg_o,
    output logic        ex_regwrite_o,
    output logic        illegal_o
);

    localparam logic [3:0] C_CTRL_ADD = 4'b0010;

    logic [3:0]  ctrl_d;
    logic        illegal_d;

    logic        valid_q;
    logic [3:0]  ctrl_q;
    logic        illegal_q;
    logic        alusrc_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  wreg_q;
    logic        regwrite_q;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        ctrl_d    = C_CTRL_ADD;
        illegal_d = 1'b0;
        unique case (id_aluop_i)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b11: ctrl_d = 4'b0001;
            default: begin
                unique case (id_funct_i)
                    6'b100000: ctrl_d = 4'b0010;
                    6'b100010: ctrl_d = 4'b0110;
                    6'b100100: ctrl_d = 4'b0000;
                    6'b100101: ctrl_d = 4'b0001;
                    6'b100111: ctrl_d = 4'b1100;
                    6'b101010: ctrl_d = 4'b0111;
                    default: begin
                        ctrl_d    = 4'b1111;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= C_CTRL_ADD;
            illegal_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            wreg_q     <= 5'd0;
            regwrite_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q    <= id_valid_i;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            alusrc_q   <= id_alusrc_i;
            rs_q       <= id_rs_i;
            rt_q       <= id_rt_i;
            rs_data_q  <= id_rs_data_i;
            rt_data_q  <= id_rt_data_i;
            imm_q      <= id_imm_i;
            wreg_q     <= id_regdst_i ? id_rd_i : id_rt_i;
            regwrite_q <= id_regwrite_i & id_valid_i & ~illegal_d;
        end
    end

    // Younger producer (EX/MEM) wins; register 0 is hard-wired and never bypassed.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] latched);
        if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == idx))
            return exmem_result_i;
        else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == idx))
            return memwb_result_i;
        else
            return latched;
    endfunction

    assign fwd_rs = fwd(rs_q, rs_data_q);
    assign fwd_rt = fwd(rt_q, rt_data_q);

    assign ex_valid_o    = valid_q;
    assign ctrl_o        = ctrl_q;
    assign src1_o        = fwd_rs;
    assign src2_o        = alusrc_q ? imm_q : fwd_rt;
    assign ex_rt_data_o  = fwd_rt;
    assign ex_wreg_o     = wreg_q;
    assign ex_regwrite_o = regwrite_q;
    assign illegal_o     = illegal_q & valid_q;

endmodule
`default_nettype wire
